// File: rtl/game_turn_controller_if.sv
// Signal bundle between the turn controller and the game-side blocks
// (move entry, board checker, display).
interface game_turn_controller_if;
    logic       start;
    logic       ft;
    logic       win;
    logic       board_full;
    logic       enable;
    logic       jugador;
    logic       new_game;
    logic [5:0] time_left;
    logic       timeout;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output start, ft, win, board_full,
        input  enable, jugador, new_game, time_left, timeout, game_over, winner
    );

    modport slave (
        input  start, ft, win, board_full,
        output enable, jugador, new_game, time_left, timeout, game_over, winner
    );
endinterface

// File: rtl/game_turn_controller.sv
// Two-player turn sequencer with a per-turn countdown in whole seconds,
// win/draw resolution and restart from the game-over state.
module game_turn_controller #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TURN_SEC = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    game_turn_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        CHECK,
        SWITCH,
        GAME_OVER
    } state_t;

    localparam int               PRE_W     = $clog2(CLK_FREQ);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ - 1);
    localparam logic [5:0]       TURN_INIT = 6'(TURN_SEC);

    state_t           state, state_nx;
    logic             jugador, jugador_nx;
    logic [5:0]       time_left, time_left_nx;
    logic [PRE_W-1:0] prescaler, prescaler_nx;
    logic [1:0]       winner, winner_nx;
    logic             new_game_q, new_game_nx;
    logic             timeout_q, timeout_nx;
    logic             tick;

    assign tick = (prescaler == PRE_LAST);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nx     = state;
        jugador_nx   = jugador;
        time_left_nx = time_left;
        prescaler_nx = prescaler;
        winner_nx    = winner;
        new_game_nx  = 1'b0;
        timeout_nx   = 1'b0;

        case (state)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_nx     = TURN;
                    new_game_nx  = 1'b1;
                    jugador_nx   = 1'b0;
                    time_left_nx = TURN_INIT;
                    prescaler_nx = '0;
                    winner_nx    = 2'b00;
                end
            end

            TURN: begin
                // A finished move wins over an expiring tick in the same cycle.
                if (bus.ft) begin
                    state_nx = CHECK;
                end else begin
                    prescaler_nx = tick ? '0 : prescaler + PRE_W'(1);
                    if (tick) begin
                        time_left_nx = time_left - 6'd1;
                        if (time_left == 6'd1) begin
                            state_nx   = SWITCH;
                            timeout_nx = 1'b1;
                        end
                    end
                end
            end

            CHECK: begin
                if (bus.win) begin
                    state_nx  = GAME_OVER;
                    winner_nx = {jugador, ~jugador};
                end else if (bus.board_full) begin
                    state_nx  = GAME_OVER;
                    winner_nx = 2'b11;
                end else begin
                    state_nx = SWITCH;
                end
            end

            SWITCH: begin
                state_nx     = TURN;
                jugador_nx   = ~jugador;
                time_left_nx = TURN_INIT;
                prescaler_nx = '0;
            end

            default: state_nx = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            jugador    <= 1'b0;
            time_left  <= TURN_INIT;
            prescaler  <= '0;
            winner     <= 2'b00;
            new_game_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            jugador    <= jugador_nx;
            time_left  <= time_left_nx;
            prescaler  <= prescaler_nx;
            winner     <= winner_nx;
            new_game_q <= new_game_nx;
            timeout_q  <= timeout_nx;
        end
    end

    assign bus.enable    = (state == TURN);
    assign bus.game_over = (state == GAME_OVER);
    assign bus.jugador   = jugador;
    assign bus.time_left = time_left;
    assign bus.winner    = winner;
    assign bus.new_game  = new_game_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller with CLK_FREQ=4, TURN_SEC=3.
module tb_game_turn_controller;

    logic clk;
    logic reset;
    int   passes;
    int   total;

    game_turn_controller_if bus ();

    game_turn_controller #(
        .CLK_FREQ (4),
        .TURN_SEC (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        passes = 0;
        total  = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.ft         = 1'b0;
        bus.win        = 1'b0;
        bus.board_full = 1'b0;
        step(2);

        // Reset state
        check("rst_enable",    bus.enable,    0);
        check("rst_jugador",   bus.jugador,   0);
        check("rst_time_left", bus.time_left, 3);
        check("rst_new_game",  bus.new_game,  0);
        check("rst_timeout",   bus.timeout,   0);
        check("rst_game_over", bus.game_over, 0);
        check("rst_winner",    bus.winner,    0);

        // ft in IDLE is ignored
        reset  = 1'b0;
        bus.ft = 1'b1;
        step();
        check("idle_ft_ignored", bus.enable, 0);
        bus.ft = 1'b0;

        // Start a game
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("start_new_game",  bus.new_game,  1);
        check("start_enable",    bus.enable,    1);
        check("start_jugador",   bus.jugador,   0);
        check("start_time_left", bus.time_left, 3);
        step();
        check("new_game_one_cycle", bus.new_game, 0);

        // ft without win/full: CHECK, SWITCH, then player 1's turn
        bus.ft = 1'b1;
        step();
        bus.ft = 1'b0;
        check("check_enable_low", bus.enable,    0);
        check("check_time_frozen", bus.time_left, 3);
        step();
        check("switch_enable_low", bus.enable, 0);
        step();
        check("turn2_enable",    bus.enable,    1);
        check("turn2_jugador",   bus.jugador,   1);
        check("turn2_time_left", bus.time_left, 3);

        // Countdown to timeout; a start pulse mid-turn is ignored
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("turn_start_ignored_ng",  bus.new_game, 0);
        check("turn_start_ignored_jug", bus.jugador,  1);
        step(2);
        check("tl_before_tick", bus.time_left, 3);
        step();
        check("tl_after_4",     bus.time_left, 2);
        step(4);
        check("tl_after_8",     bus.time_left, 1);
        step(3);
        check("tl_after_11",    bus.time_left, 1);
        check("no_early_timeout", bus.timeout, 0);
        step();
        check("tl_after_12",    bus.time_left, 0);
        check("timeout_pulse",  bus.timeout,   1);
        check("timeout_enable", bus.enable,    0);
        step();
        check("timeout_one_cycle", bus.timeout,  0);
        check("after_to_jugador",  bus.jugador,  0);
        check("after_to_reload",   bus.time_left, 3);
        check("after_to_enable",   bus.enable,   1);

        // Player 0 passes, player 1 wins
        bus.ft = 1'b1;
        step();
        bus.ft = 1'b0;
        step(2);
        check("p1_turn_jugador", bus.jugador, 1);
        bus.ft  = 1'b1;
        bus.win = 1'b1;
        step();
        bus.ft = 1'b0;
        step();
        bus.win = 1'b0;
        check("win_game_over", bus.game_over, 1);
        check("win_winner",    bus.winner,    2'b10);
        check("win_enable",    bus.enable,    0);
        bus.ft = 1'b1;
        step();
        bus.ft = 1'b0;
        check("go_ft_ignored_go",  bus.game_over, 1);
        check("go_ft_ignored_win", bus.winner,    2'b10);
        check("go_hold_jugador",   bus.jugador,   1);

        // Restart from GAME_OVER
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("restart_new_game",  bus.new_game,  1);
        check("restart_jugador",   bus.jugador,   0);
        check("restart_winner",    bus.winner,    0);
        check("restart_game_over", bus.game_over, 0);
        check("restart_time_left", bus.time_left, 3);

        // ft coincides with the expiring tick
        step(11);
        check("coinc_tl_before", bus.time_left, 1);
        bus.ft         = 1'b1;
        bus.board_full = 1'b1;
        step();
        bus.ft = 1'b0;
        check("coinc_no_timeout", bus.timeout,   0);
        check("coinc_in_check",   bus.enable,    0);
        check("coinc_tl_frozen",  bus.time_left, 1);
        step();
        bus.board_full = 1'b0;
        check("draw_game_over", bus.game_over, 1);
        check("draw_winner",    bus.winner,    2'b11);

        // Reset mid-turn at time_left=1 on the would-be expiring cycle
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(11);
        check("pre_reset_tl", bus.time_left, 1);
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset_enable",    bus.enable,    0);
        check("reset_time_left", bus.time_left, 3);
        check("reset_timeout",   bus.timeout,   0);
        check("reset_new_game",  bus.new_game,  0);
        check("reset_game_over", bus.game_over, 0);
        step();
        check("reset_stays_idle", bus.enable,  0);
        check("reset_no_late_to", bus.timeout, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/game_turn_controller.md
GAME_TURN_CONTROLLER -- requirements
Module: game_turn_controller

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving clock cycles per one-second tick (minimum 2).
REQ-002 The block SHALL have parameter TURN_SEC, default 10, giving seconds allowed per turn (range 1..63).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: debounced single-cycle pulse that begins a game.
REQ-006 The block SHALL have port ft, input, 1 bit: turn-finished flag from the move-entry block; held high until that block sees enable low.
REQ-007 The block SHALL have port win, input, 1 bit: win flag from the external board checker, valid for the last-placed piece.
REQ-008 The block SHALL have port board_full, input, 1 bit: all 42 cells occupied.
REQ-009 The block SHALL have port enable, output, 1 bit: allows the move-entry block to accept buttons.
REQ-010 The block SHALL have port jugador, output, 1 bit: current player (0 or 1).
REQ-011 The block SHALL have port new_game, output, 1 bit: one-cycle pulse that clears the board and move-entry block.
REQ-012 The block SHALL have port time_left, output, 6 bits: whole seconds remaining in the current turn.
REQ-013 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a turn expires.
REQ-014 The block SHALL have port game_over, output, 1 bit: high while in GAME_OVER.
REQ-015 The block SHALL have port winner, output, 2 bits: 00 none, 01 player 0, 10 player 1, 11 draw.

Function
REQ-016 The FSM SHALL have states IDLE, TURN, CHECK, SWITCH and GAME_OVER, with one transition per clock at most.
REQ-017 enable SHALL equal 1 only in TURN (combinational decode of state) and SHALL be 0 in every other state.
REQ-018 IDLE: on start=1 the FSM SHALL go to TURN, pulse new_game, set jugador=0, set time_left=TURN_SEC, clear the prescaler and set winner=00.
REQ-019 TURN: a prescaler SHALL count 0..CLK_FREQ-1 and produce a tick on the terminal count; each tick SHALL decrement time_left.
REQ-020 TURN: ft=1 SHALL move the FSM to CHECK on the next edge and freeze time_left.
REQ-021 TURN: a tick with time_left=1 and ft=0 SHALL set time_left=0, pulse timeout for one cycle, and move the FSM to SWITCH with no piece placed.
REQ-022 TURN: when ft=1 and the expiring tick occur in the same cycle, ft SHALL take priority and no timeout pulse SHALL occur.
REQ-023 CHECK SHALL last exactly one cycle and sample win and board_full in that cycle.
REQ-024 CHECK: win=1 SHALL move the FSM to GAME_OVER with winner={jugador, ~jugador}; win has priority over board_full.
REQ-025 CHECK: win=0 and board_full=1 SHALL move the FSM to GAME_OVER with winner=11.
REQ-026 CHECK: win=0 and board_full=0 SHALL move the FSM to SWITCH.
REQ-027 SWITCH SHALL toggle jugador, reload time_left=TURN_SEC, clear the prescaler and go to TURN, giving 2 cycles minimum with enable low between turns so ft clears.
REQ-028 GAME_OVER SHALL hold winner, jugador and time_left; on start=1 it SHALL behave exactly as IDLE+start (REQ-018).
REQ-029 start SHALL be ignored in TURN, CHECK and SWITCH.
REQ-030 ft, win and board_full SHALL be ignored outside the states that use them.

Reset
REQ-031 reset=1 SHALL, on the next rising edge, force state=IDLE, enable=0, jugador=0, new_game=0, time_left=TURN_SEC, timeout=0, game_over=0, winner=00 and prescaler=0, regardless of state, including mid-turn or mid-timeout.
REQ-032 reset SHALL take priority over every other input in the same cycle.

Verification (CLK_FREQ=4, TURN_SEC=3)
REQ-033 reset, then start pulse -> next cycle: new_game=1 for 1 cycle, enable=1, jugador=0, time_left=3.
REQ-034 in TURN, ft=1 at cycle 5 with win=0, full=0 -> CHECK at 6, SWITCH at 7, TURN at 8 with jugador=1, time_left=3, enable low for cycles 6-7.
REQ-035 no ft for 12 cycles -> time_left goes 3,2,1,0 every 4 cycles; timeout pulses once; jugador toggles; time_left reloads to 3.
REQ-036 player 1 asserts ft with win=1 -> game_over=1, winner=10, enable=0; a later ft is ignored; start -> new_game pulse, jugador=0, winner=00.
REQ-037 ft and the final tick in the same cycle -> CHECK is entered and timeout stays 0; separately, ft with board_full=1, win=0 -> winner=11.
REQ-038 reset asserted in TURN with time_left=1 -> next edge: IDLE, enable=0, time_left=3, no timeout pulse.
